vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
Timing generator for the 800x600@72Hz video mode. It runs on the 50.0 MHz pixel clock from the PLL clock stage.
- Keeps horizontal and vertical counters.
- Produces registered hsync/vsync, an active-video flag, pixel coordinates, and line/frame start strobes.
- Feeds the pong game/render logic and the VGA output pins.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 56, horizontal front porch (pixels)
H_SYNC, 120, horizontal sync width (pixels)
H_BP, 64, horizontal back porch (pixels); H_TOTAL = 1040
V_ACTIVE, 600, visible lines per frame
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 23, vertical back porch (lines); V_TOTAL = 666
H_POL, 1, hsync active level (1 = active high)
V_POL, 1, vsync active level (1 = active high)

Ports:
px_clk  input  1  pixel clock, 50.0 MHz; the only clock
rst_n  input  1  synchronous reset, active low
hsync  output  1  horizontal sync, polarity per H_POL
vsync  output  1  vertical sync, polarity per V_POL
activevideo  output  1  high while in the visible region
x_px  output  10  pixel column 0..799; 0 outside the visible region
y_px  output  10  pixel row 0..599; 0 outside the visible region
line_start  output  1  one-cycle pulse at hc==0 of every line
frame_start  output  1  one-cycle pulse at hc==0, vc==0

Behaviour:
- Clock and reset:
  - Single clock domain (px_clk); reset is synchronous, active-low (rst_n), sampled on the px_clk rising edge.
  - No combinational path from any input to any output.
- Counters:
  - Internal counters are hc (11 bits, 0..H_TOTAL-1) and vc (10 bits, 0..V_TOTAL-1).
  - hc increments every cycle. At hc==H_TOTAL-1 it wraps to 0 and vc increments.
  - At vc==V_TOTAL-1 with hc==H_TOTAL-1, vc wraps to 0.
- While rst_n==0:
  - hc=0, vc=0.
  - hsync=~H_POL, vsync=~V_POL, activevideo=0, x_px=0, y_px=0, line_start=0, frame_start=0.
- Output registration and latency:
  - All outputs are registers decoded from the current hc/vc, so they lag the counters by exactly 1 cycle.
  - First cycle after rst_n rises: counters are (0,0).
  - Next cycle: outputs show activevideo=1, x=0, y=0, line_start=1, frame_start=1.
- Decode rules, for counter state (hc,vc):
  - active = (hc<H_ACTIVE) && (vc<V_ACTIVE).
  - hsync asserted when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (856..975).
  - vsync asserted when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (637..642). It spans whole lines, aligned to hc==0 of the line.
  - x_px = active ? hc[9:0] : 0.
  - y_px = active ? vc[9:0] : 0.
  - line_start = (hc==0), including on blanking lines.
  - frame_start = (hc==0 && vc==0).
- Frame length: exactly H_TOTAL*V_TOTAL = 692640 cycles, about 72.19 Hz at 50 MHz.
- Boundaries:
  - hc==H_TOTAL-1 and vc==V_TOTAL-1 simultaneously: both wrap in the same cycle, with no extra idle cycle.
  - Reset mid-line or mid-frame: counters return to (0,0) on the next edge; outputs go to reset values in that same edge.
  - Counting restarts cleanly with no partial sync pulse stretched across the reset.
- Parameter constraints:
  - Sums must fit the counter widths: H_TOTAL <= 2048, V_TOTAL <= 1024, H_ACTIVE <= 1024.
  - A parameter set violating this is a configuration error.

Optional Feature:
Macro: VGA_SYNC_PXEN_EN
- Defined:
  - Adds an input port px_en (1 bit), placed after rst_n.
  - Counters advance only on cycles with px_en==1. Outputs still re-register every cycle from the held counters, so levels hold.
  - line_start and frame_start pulse only on the first output cycle following a counter advance into hc==0. Held cycles do not re-pulse.
  - Reset overrides px_en.
  - Purpose: running from a faster clock with an enable, e.g. 100 MHz with px_en toggling.
- Not defined: the port is absent and counters advance every cycle.

Test Plan:
- Reset value check: hold rst_n=0 for 5 cycles -> hsync=0, vsync=0, activevideo=0, x_px=0, y_px=0, line_start=0, frame_start=0 throughout.
- Start-up timing: release rst_n -> 1 cycle later activevideo=1, x_px=0, y_px=0, frame_start=1.
- Visible region and hsync: from the same start point, x_px reaches 799 at output cycle 799 and activevideo=0 at cycle 800. hsync rises at output cycle 856, falls at 976.
- Line and frame periods: run 2 full frames -> line_start period 1040 cycles, frame_start period 692640 cycles.
  - vsync high for exactly 6*1040=6240 cycles starting at line 637, hc=0.
  - y_px holds 0 on lines 600..665.
- Reset mid-frame: assert rst_n=0 for 1 cycle at line 300, hc=400 -> next cycle outputs reset. After release, frame_start arrives 1 cycle later; the following frame_start comes 692640 cycles after that.
- With VGA_SYNC_PXEN_EN: px_en alternating 1/0 -> line_start period 2080 cycles and frame period 1385280 cycles. Holding px_en=0 for 100 cycles at x_px=10 -> x_px stays 10, with no extra line_start.

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle from vga_sync_gen to the render logic and the VGA pins.
// master drives the timing signals; slave consumes them.
interface vga_sync_gen_if;
   logic       hsync;
   logic       vsync;
   logic       activevideo;
   logic [9:0] x_px;
   logic [9:0] y_px;
   logic       line_start;
   logic       frame_start;

   modport master (
      output hsync, vsync, activevideo, x_px, y_px, line_start, frame_start
   );

   modport slave (
      input  hsync, vsync, activevideo, x_px, y_px, line_start, frame_start
   );
endinterface

// File: rtl/vga_sync_gen.sv
// 800x600@72Hz sync generator: hc/vc counters with registered sync, visible-area and strobe outputs.
// Optional macro VGA_SYNC_PXEN_EN adds a px_en input that gates counter advance.
module vga_sync_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 56,
   parameter int H_SYNC   = 120,
   parameter int H_BP     = 64,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 37,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 23,
   parameter bit H_POL    = 1'b1,
   parameter bit V_POL    = 1'b1
) (
   input  logic           px_clk,
   input  logic           rst_n,
`ifdef VGA_SYNC_PXEN_EN
   input  logic           px_en,
`endif
   vga_sync_gen_if.master vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > 2048 || V_TOTAL > 1024 || H_ACTIVE > 1024) begin : g_cfg_error
         $error("vga_sync_gen: timing parameters do not fit the hc/vc counter widths");
      end
   endgenerate

   localparam logic [10:0] HC_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_VIS_END = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEGIN  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  VC_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_VIS_END = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_BEGIN  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef struct packed {
      logic       hsync;
      logic       vsync;
      logic       activevideo;
      logic [9:0] x_px;
      logic [9:0] y_px;
      logic       line_start;
      logic       frame_start;
   } vid_t;

   localparam vid_t VID_RESET = '{
      hsync:       ~H_POL,
      vsync:       ~V_POL,
      activevideo: 1'b0,
      x_px:        10'd0,
      y_px:        10'd0,
      line_start:  1'b0,
      frame_start: 1'b0
   };

   logic [10:0] hc;
   logic [9:0]  vc;
   logic        adv;
   logic        fresh;
   logic        vis;
   vid_t        vid_d;
   vid_t        vid_q;

   // fresh marks a counter value reached on the last edge, so held cycles never repeat a strobe.
`ifdef VGA_SYNC_PXEN_EN
   assign adv = px_en;

   always_ff @(posedge px_clk) begin
      if (!rst_n) begin
         fresh <= 1'b1;
      end else begin
         fresh <= px_en;
      end
   end
`else
   assign adv   = 1'b1;
   assign fresh = 1'b1;
`endif

   always_comb begin
      // NOTE: every signal written here gets a value first, so no path leaves it unassigned and no latch is inferred.
      vid_d = VID_RESET;
      vis   = (hc < H_VIS_END) && (vc < V_VIS_END);

      vid_d.hsync       = (hc >= HS_BEGIN && hc < HS_END) ? H_POL : ~H_POL;
      vid_d.vsync       = (vc >= VS_BEGIN && vc < VS_END) ? V_POL : ~V_POL;
      vid_d.activevideo = vis;
      if (vis) begin
         vid_d.x_px = hc[9:0];
         vid_d.y_px = vc;
      end
      vid_d.line_start  = fresh && (hc == 11'd0);
      vid_d.frame_start = fresh && (hc == 11'd0) && (vc == 10'd0);
   end

   always_ff @(posedge px_clk) begin
      // NOTE: non-blocking assignments so the decode and the counters both see the pre-edge hc/vc.
      if (!rst_n) begin
         hc    <= 11'd0;
         vc    <= 10'd0;
         vid_q <= VID_RESET;
      end else begin
         vid_q <= vid_d;
         if (adv) begin
            if (hc == HC_LAST) begin
               hc <= 11'd0;
               vc <= (vc == VC_LAST) ? 10'd0 : vc + 10'd1;
            end else begin
               hc <= hc + 11'd1;
            end
         end
      end
   end

   assign vid.hsync       = vid_q.hsync;
   assign vid.vsync       = vid_q.vsync;
   assign vid.activevideo = vid_q.activevideo;
   assign vid.x_px        = vid_q.x_px;
   assign vid.y_px        = vid_q.y_px;
   assign vid.line_start  = vid_q.line_start;
   assign vid.frame_start = vid_q.frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 800x600 instance plus a tiny inverted-polarity instance for whole frames.
// Outputs are compared every cycle against a model driven by the pixel-advance count.
module tb_vga_sync_gen;

   typedef struct packed {
      longint ha, hfp, hs, hbp;
      longint va, vfp, vs, vbp;
      bit     hp, vp;
   } cfg_t;

   typedef struct packed {
      logic       hsync;
      logic       vsync;
      logic       activevideo;
      logic [9:0] x_px;
      logic [9:0] y_px;
      logic       line_start;
      logic       frame_start;
   } vid_t;

   localparam cfg_t CFG_F = '{ha: 800, hfp: 56, hs: 120, hbp: 64,
                              va: 600, vfp: 37, vs: 6, vbp: 23, hp: 1'b1, vp: 1'b1};
   localparam cfg_t CFG_S = '{ha: 16, hfp: 4, hs: 6, hbp: 3,
                              va: 10, vfp: 2, vs: 3, vbp: 2, hp: 1'b0, vp: 1'b0};
   localparam int     RUN_CYCLES = 70000;
   localparam longint MID_POINT  = 30 * 1040 + 400;

   logic clk;
   logic rst_n [2];
   logic en    [2];
   int   n_vec = 0;
   int   n_err = 0;

   vga_sync_gen_if vid_f ();
   vga_sync_gen_if vid_s ();

   vga_sync_gen dut_f (
      .px_clk (clk),
      .rst_n  (rst_n[0]),
`ifdef VGA_SYNC_PXEN_EN
      .px_en  (en[0]),
`endif
      .vid    (vid_f)
   );

   vga_sync_gen #(
      .H_ACTIVE (int'(CFG_S.ha)), .H_FP (int'(CFG_S.hfp)),
      .H_SYNC   (int'(CFG_S.hs)), .H_BP (int'(CFG_S.hbp)),
      .V_ACTIVE (int'(CFG_S.va)), .V_FP (int'(CFG_S.vfp)),
      .V_SYNC   (int'(CFG_S.vs)), .V_BP (int'(CFG_S.vbp)),
      .H_POL    (CFG_S.hp),       .V_POL (CFG_S.vp)
   ) dut_s (
      .px_clk (clk),
      .rst_n  (rst_n[1]),
`ifdef VGA_SYNC_PXEN_EN
      .px_en  (en[1]),
`endif
      .vid    (vid_s)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic cfg_t cfg_of(int i);
      return (i == 0) ? CFG_F : CFG_S;
   endfunction

   function automatic longint h_total(cfg_t c);
      return c.ha + c.hfp + c.hs + c.hbp;
   endfunction

   function automatic longint v_total(cfg_t c);
      return c.va + c.vfp + c.vs + c.vbp;
   endfunction

   function automatic vid_t ref_idle(cfg_t c);
      vid_t r;
      r       = '0;
      r.hsync = ~c.hp;
      r.vsync = ~c.vp;
      return r;
   endfunction

   // Expected outputs once the counters have advanced n times since reset.
   function automatic vid_t ref_pixel(cfg_t c, longint n, bit moved);
      longint h, v;
      bit     in_vis;
      vid_t   r;
      h             = n % h_total(c);
      v             = (n / h_total(c)) % v_total(c);
      in_vis        = (h < c.ha) && (v < c.va);
      r.hsync       = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? c.hp : ~c.hp;
      r.vsync       = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? c.vp : ~c.vp;
      r.activevideo = in_vis;
      r.x_px        = in_vis ? 10'(h) : 10'd0;
      r.y_px        = in_vis ? 10'(v) : 10'd0;
      r.line_start  = moved && (h == 0);
      r.frame_start = moved && (h == 0) && (v == 0);
      return r;
   endfunction

   function automatic vid_t obs(int i);
      if (i == 0)
         return {vid_f.hsync, vid_f.vsync, vid_f.activevideo, vid_f.x_px, vid_f.y_px,
                 vid_f.line_start, vid_f.frame_start};
      return {vid_s.hsync, vid_s.vsync, vid_s.activevideo, vid_s.x_px, vid_s.y_px,
              vid_s.line_start, vid_s.frame_start};
   endfunction

   vid_t   exp_v       [2];
   longint n_adv       [2];
   longint adv_tot     [2];
   longint adv_at_edge [2];
   bit     moved       [2];
   bit     live        [2];
   bit     was_rst     [2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         adv_at_edge[i] <= adv_tot[i];
         was_rst[i]     <= !rst_n[i];
         live[i]        <= 1'b1;
         if (!rst_n[i]) begin
            exp_v[i] <= ref_idle(cfg_of(i));
            n_adv[i] <= 0;
            moved[i] <= 1'b1;
         end else begin
            exp_v[i] <= ref_pixel(cfg_of(i), n_adv[i], moved[i]);
            if (en[i] === 1'b1) begin
               n_adv[i]   <= n_adv[i] + 1;
               adv_tot[i] <= adv_tot[i] + 1;
            end
            moved[i] <= (en[i] === 1'b1);
         end
      end
   end

   // Period trackers, measured in counter advances between observed strobes.
   bit     have_ls [2];
   bit     have_fs [2];
   bit     have_vs [2];
   bit     vs_prev [2];
   longint ls_mark [2];
   longint fs_mark [2];
   longint vs_mark [2];

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         vid_t  o;
         cfg_t  c;
         bit    vs_on;
         string nm;
         if (live[i]) begin
            o  = obs(i);
            c  = cfg_of(i);
            nm = (i == 0) ? "full" : "small";
            check({nm, "_vid"}, 64'(o), 64'(exp_v[i]));
            if (was_rst[i]) begin
               have_ls[i] <= 1'b0;
               have_fs[i] <= 1'b0;
               have_vs[i] <= 1'b0;
               vs_prev[i] <= 1'b0;
            end else begin
               if (o.line_start === 1'b1) begin
                  if (have_ls[i])
                     check({nm, "_line_period"}, 64'(adv_at_edge[i] - ls_mark[i]), 64'(h_total(c)));
                  ls_mark[i] <= adv_at_edge[i];
                  have_ls[i] <= 1'b1;
               end
               if (o.frame_start === 1'b1) begin
                  if (have_fs[i])
                     check({nm, "_frame_period"}, 64'(adv_at_edge[i] - fs_mark[i]),
                           64'(h_total(c) * v_total(c)));
                  fs_mark[i] <= adv_at_edge[i];
                  have_fs[i] <= 1'b1;
               end
               vs_on = (o.vsync === c.vp);
               if (vs_on && !vs_prev[i]) begin
                  vs_mark[i] <= adv_at_edge[i];
                  have_vs[i] <= 1'b1;
               end
               if (!vs_on && vs_prev[i] && have_vs[i])
                  check({nm, "_vsync_len"}, 64'(adv_at_edge[i] - vs_mark[i]), 64'(c.vs * h_total(c)));
               vs_prev[i] <= vs_on;
            end
         end
      end
   end

   initial begin
      bit mid_done;
      int s_rst_left;
`ifdef VGA_SYNC_PXEN_EN
      bit hold_done;
      int hold_left;
      int hold_ls;
      hold_done = 1'b0;
      hold_left = 0;
      hold_ls   = 0;
`endif
      mid_done   = 1'b0;
      s_rst_left = 0;
      rst_n[0]   = 1'b0;
      rst_n[1]   = 1'b0;
      en[0]      = 1'b1;
      en[1]      = 1'b1;

      repeat (5) @(negedge clk);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;

      for (int c = 0; c < RUN_CYCLES; c++) begin
         @(negedge clk);
         // Full-size instance: one single-cycle reset in the middle of line 30.
         if (!mid_done && n_adv[0] >= MID_POINT) begin
            rst_n[0] = 1'b0;
            mid_done = 1'b1;
         end else begin
            rst_n[0] = 1'b1;
         end

         if (s_rst_left > 0) begin
            rst_n[1] = 1'b0;
            s_rst_left--;
         end else if ($urandom_range(2999, 0) == 0) begin
            rst_n[1]   = 1'b0;
            s_rst_left = int'($urandom_range(2, 0));
         end else begin
            rst_n[1] = 1'b1;
         end

`ifdef VGA_SYNC_PXEN_EN
         en[1] = ($urandom_range(3, 0) != 0);
         if (hold_left > 0) begin
            en[0] = 1'b0;
            if (vid_f.line_start !== 1'b0) hold_ls++;
            hold_left--;
            if (hold_left == 0) begin
               check("hold_x_px", 64'(vid_f.x_px), 64'd10);
               check("hold_line_start", 64'(hold_ls), 64'd0);
            end
         end else if (!hold_done && n_adv[0] == 2 * 1040 + 10) begin
            en[0]     = 1'b0;
            hold_left = 100;
            hold_done = 1'b1;
         end else begin
            en[0] = ($urandom_range(3, 0) != 0);
         end
`endif
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
